// File: rtl/core_pipe_stage_pkg.sv
// Shared types and defaults for the core pipeline stage register.
// The skid-entry FSM states are only used when CORE_PIPE_SKID_EN is defined.
package core_pipe_stage_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32'd256;
    localparam int unsigned DEF_HOLD_WIDTH = 32'd3;
    localparam int unsigned DEF_HOLD_LEVEL = 32'd3;
    localparam int unsigned DEF_CNT_WIDTH  = 32'd16;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/core_pipe_stage_if.sv
// Valid/ready/payload link between two pipeline stages.
// The master drives the payload; the slave answers with ready.
interface core_pipe_stage_if #(
    parameter int unsigned DATA_WIDTH = 32'd256
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/core_pipe_skid.sv
// Skid entry and occupancy FSM for core_pipe_stage (used only with CORE_PIPE_SKID_EN).
// Tracks main/skid occupancy; payload of the main entry stays in the parent.
module core_pipe_skid
    import core_pipe_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic                  in_fire_i,
    input  logic                  out_fire_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  main_valid_o,
    output logic                  skid_valid_o,
    output logic [DATA_WIDTH-1:0] skid_data_o
);

    pipe_state_e           state_q;
    logic                  main_valid_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_data_q;

    // Occupancy FSM with registered valids; flush behaves like reset
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            state_q      <= PIPE_EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VALUE;
        end else if (!hold_i) begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (in_fire_i) begin
                        state_q      <= PIPE_FULL;
                        main_valid_q <= 1'b1;
                    end
                end
                PIPE_FULL: begin
                    if (in_fire_i && !out_fire_i) begin
                        state_q      <= PIPE_SKID;
                        skid_valid_q <= 1'b1;
                        skid_data_q  <= in_data_i;
                    end else if (out_fire_i && !in_fire_i) begin
                        state_q      <= PIPE_EMPTY;
                        main_valid_q <= 1'b0;
                    end
                end
                PIPE_SKID: begin
                    if (out_fire_i) begin
                        state_q      <= PIPE_FULL;
                        skid_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= PIPE_EMPTY;
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign main_valid_o = main_valid_q;
    assign skid_valid_o = skid_valid_q;
    assign skid_data_o  = skid_data_q;

endmodule

// File: rtl/core_pipe_stage.sv
// Pipeline register with valid/ready handshake, flush, level hold and saturating stall counter.
// Define CORE_PIPE_SKID_EN to add a skid entry that makes in_ready a registered term.
module core_pipe_stage
    import core_pipe_stage_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
    parameter int unsigned           HOLD_WIDTH = DEF_HOLD_WIDTH,
    parameter int unsigned           HOLD_LEVEL = DEF_HOLD_LEVEL,
    parameter int unsigned           CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HOLD_WIDTH-1:0] hold_flag_in,
    input  logic                  flush_in,
    core_pipe_stage_if.slave      up_if,
    core_pipe_stage_if.master     dn_if,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    logic                  hold_s;
    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  main_valid_s;
    logic                  skid_valid_s;
    logic                  load_in_s;
    logic                  load_skid_s;
    logic [DATA_WIDTH-1:0] skid_data_s;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [DATA_WIDTH-1:0] main_data_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_d;

    assign hold_s      = (hold_flag_in >= HOLD_WIDTH'(HOLD_LEVEL));
    assign out_valid_s = main_valid_s && !hold_s && !flush_in;
    assign in_fire_s   = up_if.valid && in_ready_s;
    assign out_fire_s  = out_valid_s && dn_if.ready;
    // Main reloads from input when empty or draining; otherwise it refills from the skid entry
    assign load_in_s   = in_fire_s && (!main_valid_s || out_fire_s);
    assign load_skid_s = out_fire_s && skid_valid_s;

`ifdef CORE_PIPE_SKID_EN
    assign in_ready_s = !skid_valid_s && !hold_s && !flush_in;

    core_pipe_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_VALUE  (NOP_VALUE)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_in),
        .hold_i       (hold_s),
        .in_fire_i    (in_fire_s),
        .out_fire_i   (out_fire_s),
        .in_data_i    (up_if.data),
        .main_valid_o (main_valid_s),
        .skid_valid_o (skid_valid_s),
        .skid_data_o  (skid_data_s)
    );
`else
    logic main_valid_q;
    logic main_valid_d;

    assign in_ready_s   = !hold_s && !flush_in && (!main_valid_q || dn_if.ready);
    assign main_valid_s = main_valid_q;
    assign skid_valid_s = 1'b0;
    assign skid_data_s  = NOP_VALUE;

    // Single-entry occupancy next state
    always_comb begin
        main_valid_d = main_valid_q;
        if (flush_in) begin
            main_valid_d = 1'b0;
        end else if (in_fire_s) begin
            main_valid_d = 1'b1;
        end else if (out_fire_s) begin
            main_valid_d = 1'b0;
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    // Single-entry occupancy register
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
        end
    end
`endif

    // Payload and stall-counter next state; the payload is kept after a drain
    always_comb begin
        main_data_d = main_data_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_in) begin
            main_data_d = NOP_VALUE;
        end else if (load_in_s) begin
            main_data_d = up_if.data;
        end else if (load_skid_s) begin
            main_data_d = skid_data_s;
        end else begin
            main_data_d = main_data_q;
        end
        if (up_if.valid && !in_ready_s && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Payload and stall-counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_data_q <= NOP_VALUE;
            stall_cnt_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign up_if.ready = in_ready_s;
    assign dn_if.valid = out_valid_s;
    assign dn_if.data  = main_data_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
